mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master arbiter placed in front of the physical memory controller's CPU-facing port (addr / data_in / data_out / is_write / busy).
- Lets the CPU (master 0) share the memory and I/O address space with a second bus master (master 1, e.g. an Ethernet/VGA DMA engine).
- Serialises accesses one at a time, so exactly one transaction is outstanding downstream.
- Provides per-master request/acknowledge handshakes and a watchdog that aborts transactions the downstream never completes.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 always wins.
- TIMEOUT_CYCLES, 1023, wait-state cycles before an access is aborted; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 request; held high until m0_ack.
- m0_addr  input  32  master 0 address.
- m0_wdata  input  32  master 0 write data.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_rdata  output  32  master 0 read data; valid in the m0_ack cycle and held afterwards.
- m0_ack  output  1  one-cycle completion pulse.
- m0_err  output  1  qualifies m0_ack; 1 = timed out.
- m1_req, m1_addr, m1_wdata, m1_we, m1_rdata, m1_ack, m1_err: same as master 0.
- mem_addr  output  32  downstream address.
- mem_wdata  output  32  downstream write data.
- mem_is_write  output  1  downstream write strobe qualifier.
- mem_start  output  1  one-cycle launch pulse.
- mem_rdata  input  32  downstream read data; valid when mem_busy falls.
- mem_busy  input  1  downstream busy; must rise no later than the cycle after mem_start.
- grant  output  1  index of the master owning the bus (debug/segment display).

Behaviour:
- Reset values (rst low, asynchronous): state IDLE, all outputs 0, last-grant pointer = 1 so master 0 wins the first tie, timeout counter 0.
- IDLE, no request: stay in IDLE.
- IDLE, one request: select that master.
- IDLE, both requests:
  - PRIO_MODE=1: select master 0.
  - PRIO_MODE=0: select the master not granted last.
- IDLE, on selection: latch the selected master's addr/wdata/we into mem_addr/mem_wdata/mem_is_write and its index into grant; go to ISSUE.
- ISSUE (exactly 1 cycle): mem_start=1; clear timeout counter; go to WAIT.
- WAIT:
  - First WAIT cycle: mem_busy is ignored (guard cycle).
  - From the second cycle on: mem_busy==0 -> go to DONE with err=0.
  - Counter increments every WAIT cycle; reaching TIMEOUT_CYCLES -> go to DONE with err=1.
  - If mem_busy falls in the same cycle the counter reaches the limit, completion wins (err=0).
- DONE (exactly 1 cycle):
  - Granted master's ack=1 and err=flag.
  - rdata = mem_rdata for reads; for writes rdata is unchanged.
  - On timeout, rdata = 32'hFFFFFFFF.
  - Update last-grant pointer; go to IDLE.
- Latency: req sampled in IDLE at edge N -> mem_start high in cycle N+1 -> ack no earlier than cycle N+4 (zero-wait downstream).
- Back-to-back: a master holding req after its ack is re-arbitrated in the next IDLE cycle. One IDLE cycle always separates transactions.
- Signal stability:
  - Address/data/we are latched at grant; requester changes after grant are ignored until the next arbitration.
  - mem_addr/mem_wdata/mem_is_write hold their values until the next grant.
- Requester dropping req after grant: the transaction still completes and ack is still pulsed.
- Ack exclusivity: m0_ack and m1_ack are never high in the same cycle.
- Reset mid-transaction: immediate return to IDLE with outputs cleared; no ack is issued. Downstream recovery is handled by its own reset.
- Counter width: 16 bits, saturating; never wraps.

Test Plan:
- Single read: m0 reads 0x00000040, downstream busy 3 cycles then mem_rdata=0xDEADBEEF -> mem_start pulses once with mem_addr=0x40, mem_is_write=0; m0_ack 1 cycle with m0_rdata=0xDEADBEEF, m0_err=0.
- Round-robin contention (PRIO_MODE=0): m0 and m1 both hold req for 4 transactions -> grant sequence 0,1,0,1; acks never overlap; one IDLE cycle between transactions.
- Fixed priority (PRIO_MODE=1): both requesting continuously -> master 0 served every time; m1 served only after m0_req drops.
- Write with latching: m1 writes 0x1234_5678 to 0xBFD003F8; m1_addr changes to 0x0 one cycle after grant -> mem_addr stays 0xBFD003F8 and mem_wdata stays 0x12345678 until m1_ack.
- Timeout (TIMEOUT_CYCLES=8): mem_busy stuck high -> m0_ack with m0_err=1 and m0_rdata=0xFFFFFFFF after 8 WAIT cycles; the next request is served normally.
- Async reset: rst driven low during WAIT, between clock edges -> all outputs 0 immediately and no ack; after release, the first simultaneous request goes to master 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-outstanding memory controller port.
// Round-robin or fixed-priority selection, with a watchdog that aborts stuck accesses.

module mem_arbiter_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        timeout,
  input  logic        is_write,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata
);
  // Writes leave the last read value in place; an aborted access reads as all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      rdata <= '0;
    else if (capture && timeout)   rdata <= 32'hFFFF_FFFF;
    else if (capture && !is_write) rdata <= mem_rdata;
  end
endmodule

module mem_arbiter #(
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_is_write,
  output logic        mem_start,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  output logic        grant
);
  localparam int          NUM_M = 2;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NUM_M-1:0]       req, we, ack, err;
  logic [NUM_M-1:0][31:0] addr, wdata, rdata;
  logic                   sel, do_grant, last_grant, err_q, err_nxt, capture;
  logic [15:0]            cnt, cnt_inc;

  assign req     = {m1_req, m0_req};
  assign we      = {m1_we, m0_we};
  assign addr    = {m1_addr, m0_addr};
  assign wdata   = {m1_wdata, m0_wdata};
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign capture = (state == WAIT) && (state_nxt == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel       = grant;
    do_grant  = 1'b0;
    err_nxt   = err_q;
    case (state)
      IDLE: if (|req) begin
        do_grant  = 1'b1;
        state_nxt = ISSUE;
        if (&req) sel = (PRIO_MODE != 0) ? 1'b0 : ~last_grant;
        else      sel = req[1];
      end
      ISSUE: state_nxt = WAIT;
      // cnt==0 marks the guard cycle; completion beats a simultaneous timeout.
      WAIT: if (cnt != 16'd0 && !mem_busy) begin
        state_nxt = DONE;
        err_nxt   = 1'b0;
      end else if (cnt_inc >= LIMIT) begin
        state_nxt = DONE;
        err_nxt   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_start  = (state == ISSUE);
    ack        = '0;
    if (state == DONE) ack[grant] = 1'b1;
    err        = ack & {NUM_M{err_q}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_is_write <= 1'b0;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      err_q        <= 1'b0;
    end else begin
      if (do_grant) begin
        mem_addr     <= addr[sel];
        mem_wdata    <= wdata[sel];
        mem_is_write <= we[sel];
        grant        <= sel;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt_inc;
      if (capture)            err_q <= err_nxt;
      if (state == DONE)      last_grant <= grant;
    end
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_resp
    mem_arbiter_resp u_resp (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture && (grant == 1'(i))),
      .timeout   (err_nxt),
      .is_write  (mem_is_write),
      .mem_rdata (mem_rdata),
      .rdata     (rdata[i])
    );
  end

  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];
  assign m0_ack   = ack[0];
  assign m1_ack   = ack[1];
  assign m0_err   = err[0];
  assign m1_err   = err[1];
endmodule
